// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the decimal keypad entry block.
package decimal_entry_pkg;

    localparam int DIGIT_MAX  = 9;
    localparam int MAX_DIGITS = 2;
    localparam int BIN_W      = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/decimal_entry_bcd_mac10.sv
// Multiply-by-ten and add one BCD digit, built from shifts and adds only.
module bcd_mac10
    import decimal_entry_pkg::*;
(
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] acc_next
);

    assign acc_next = (acc << 3) + (acc << 1) + {{(BIN_W-4){1'b0}}, digit};

endmodule

// File: rtl/decimal_entry.sv
// Two-digit decimal keypad entry, committed as a binary value 0..99.
// Define DECIMAL_ENTRY_ROLL_EN to let a third digit push out the oldest one instead of erroring.
//
// state | meaning
// EMPTY | no digits held
// ONE   | one digit held
// TWO   | two digits held
// ERR   | bad or excess digit seen; waits for clear_i
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int TIMEOUT_CYC = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       digit_i,
    input  logic             digit_valid_i,
    input  logic             enter_i,
    input  logic             clear_i,
    output logic [BIN_W-1:0] bin_o,
    output logic             bin_valid_o,
    output logic [3:0]       tens_o,
    output logic [3:0]       ones_o,
    output logic [1:0]       ndig_o,
    output logic             err_o
);

`ifdef DECIMAL_ENTRY_ROLL_EN
    localparam bit ROLL_EN = 1'b1;
`else
    localparam bit ROLL_EN = 1'b0;
`endif

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(TIMEOUT_CYC);

    state_t           state_q, state_d;
    logic [BIN_W-1:0] acc_q, acc_d, bin_q, bin_d, mac_acc, mac_out;
    logic [3:0]       tens_q, tens_d, ones_q, ones_d;
    logic [1:0]       ndig_q, ndig_d;
    logic             bin_valid_q, bin_valid_d, err_q, err_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             digit_ok, drop;

    assign digit_ok = digit_valid_i && (digit_i <= 4'(DIGIT_MAX));

    // Rolling in TWO keeps only the ones digit, so acc%10 is just ones_q.
    assign mac_acc = (ROLL_EN && state_q == TWO) ? {{(BIN_W-4){1'b0}}, ones_q} : acc_q;

    bcd_mac10 u_mac (
        .acc      (mac_acc),
        .digit    (digit_i),
        .acc_next (mac_out)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        ndig_d      = ndig_q;
        bin_d       = bin_q;
        bin_valid_d = 1'b0;
        idle_d      = idle_q;
        drop        = 1'b0;

        if (clear_i) begin
            drop = 1'b1;
        end else if (state_q != ERR) begin
            if (digit_valid_i && (!digit_ok || (state_q == TWO && !ROLL_EN))) begin
                state_d = ERR;
                idle_d  = '0;
            end else begin
                if (digit_valid_i) begin
                    acc_d   = mac_out;
                    tens_d  = ones_q;
                    ones_d  = digit_i;
                    idle_d  = IDLE_LOAD;
                    state_d = (state_q == EMPTY) ? ONE : TWO;
                    ndig_d  = (state_q == EMPTY) ? 2'd1 : 2'(MAX_DIGITS);
                end
                // Commit sees the digit applied in this same cycle.
                if (enter_i && state_d != EMPTY) begin
                    bin_d       = acc_d;
                    bin_valid_d = 1'b1;
                    drop        = 1'b1;
                end else if (!digit_valid_i && idle_q != '0) begin
                    if (idle_q == CNT_W'(1)) begin
                        drop = 1'b1;
                    end else begin
                        idle_d = idle_q - 1'b1;
                    end
                end
            end
        end

        if (drop) begin
            state_d = EMPTY;
            acc_d   = '0;
            tens_d  = '0;
            ones_d  = '0;
            ndig_d  = '0;
            idle_d  = '0;
        end

        err_d = (state_d == ERR);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            acc_q       <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            ndig_q      <= '0;
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
            err_q       <= 1'b0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            ndig_q      <= ndig_d;
            bin_q       <= bin_d;
            bin_valid_q <= bin_valid_d;
            err_q       <= err_d;
            idle_q      <= idle_d;
        end
    end

    assign bin_o       = bin_q;
    assign bin_valid_o = bin_valid_q;
    assign tens_o      = tens_q;
    assign ones_o      = ones_q;
    assign ndig_o      = ndig_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_decimal_entry.sv
// Self-checking bench for decimal_entry: directed scenarios, then random traffic against a digit-list model.
module tb_decimal_entry;

    localparam int TMO = 16;
`ifdef DECIMAL_ENTRY_ROLL_EN
    localparam bit ROLL = 1'b1;
`else
    localparam bit ROLL = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] digit_i = '0;
    logic       digit_valid_i = 1'b0;
    logic       enter_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [7:0] bin_o;
    logic       bin_valid_o;
    logic [3:0] tens_o, ones_o;
    logic [1:0] ndig_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: the entry is a plain list of decimal digits.
    int q[$];
    bit m_err   = 1'b0;
    int m_bin   = 0;
    bit m_pulse = 1'b0;
    int m_idle  = 0;

    decimal_entry #(.TIMEOUT_CYC(TMO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .digit_i       (digit_i),
        .digit_valid_i (digit_valid_i),
        .enter_i       (enter_i),
        .clear_i       (clear_i),
        .bin_o         (bin_o),
        .bin_valid_o   (bin_valid_o),
        .tens_o        (tens_o),
        .ones_o        (ones_o),
        .ndig_o        (ndig_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int entry_value();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_err = 1'b0; m_bin = 0; m_pulse = 1'b0; m_idle = 0;
    endtask

    task automatic model_step(input bit dv, input int d, input bit en, input bit clr);
        bit accepted = 1'b0;
        m_pulse = 1'b0;
        if (clr) begin
            q.delete(); m_err = 1'b0; m_idle = 0;
        end else if (!m_err) begin
            if (dv) begin
                if (d > 9 || (q.size() == 2 && !ROLL)) begin
                    m_err = 1'b1;
                end else begin
                    q.push_back(d);
                    if (q.size() > 2) void'(q.pop_front());
                    accepted = 1'b1;
                    m_idle = 0;
                end
            end
            if (!m_err) begin
                if (en && q.size() > 0) begin
                    m_bin = entry_value(); m_pulse = 1'b1; q.delete(); m_idle = 0;
                end else if (!accepted && q.size() > 0) begin
                    m_idle++;
                    if (m_idle == TMO) begin q.delete(); m_idle = 0; end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        int t = (q.size() == 2) ? q[0] : 0;
        int o = (q.size() == 0) ? 0 : q[q.size()-1];
        chk({tag, ".bin"},   32'(bin_o),       m_bin);
        chk({tag, ".valid"}, 32'(bin_valid_o), 32'(m_pulse));
        chk({tag, ".tens"},  32'(tens_o),      t);
        chk({tag, ".ones"},  32'(ones_o),      o);
        chk({tag, ".ndig"},  32'(ndig_o),      q.size());
        chk({tag, ".err"},   32'(err_o),       32'(m_err));
    endtask

    task automatic step(input string tag, input logic dv, input logic [3:0] d,
                        input logic en, input logic clr);
        @(negedge clk_i);
        digit_valid_i = dv; digit_i = d; enter_i = en; clear_i = clr;
        @(posedge clk_i);
        model_step(dv, int'(d), en, clr);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic       dv, en, clr;
        logic [3:0] d;

        model_reset();
        repeat (2) @(posedge clk_i);
        #1 check_all("reset");
        @(negedge clk_i) rst_i = 1'b0;

        step("d4", 1'b1, 4'd4, 1'b0, 1'b0);
        step("d2", 1'b1, 4'd2, 1'b0, 1'b0);
        step("ent42", 1'b0, 4'd0, 1'b1, 1'b0);
        chk("req030.bin", 32'(bin_o), 42);
        chk("req030.pulse", 32'(bin_valid_o), 1);
        idle("after42", 1);
        chk("req030.pulse_end", 32'(bin_valid_o), 0);

        step("d7ent", 1'b1, 4'd7, 1'b1, 1'b0);
        chk("req031.bin", 32'(bin_o), 7);
        step("ent_empty", 1'b0, 4'd0, 1'b1, 1'b0);

        step("d9a", 1'b1, 4'd9, 1'b0, 1'b0);
        step("d9b", 1'b1, 4'd9, 1'b0, 1'b0);
        step("d1", 1'b1, 4'd1, 1'b0, 1'b0);
        chk("req032.err", 32'(err_o), ROLL ? 0 : 1);
        step("ent991", 1'b0, 4'd0, 1'b1, 1'b0);
        chk("req032.bin", 32'(bin_o), ROLL ? 91 : 7);
        step("d_in_err", 1'b1, 4'd3, 1'b0, 1'b0);
        step("clr", 1'b0, 4'd0, 1'b0, 1'b1);
        chk("req032.cleared", 32'(err_o), 0);

        step("dC", 1'b1, 4'hC, 1'b0, 1'b0);
        chk("req033.err", 32'(err_o), 1);
        step("clr_d5", 1'b1, 4'd5, 1'b0, 1'b1);
        chk("req033.err_clr", 32'(err_o), 0);
        chk("req033.ndig", 32'(ndig_o), 0);

        step("d3", 1'b1, 4'd3, 1'b0, 1'b0);
        idle("tmo_wait", TMO - 1);
        chk("req034.held", 32'(ndig_o), 1);
        idle("tmo_fire", 1);
        chk("req034.ndig", 32'(ndig_o), 0);
        chk("req034.ones", 32'(ones_o), 0);

        step("d8", 1'b1, 4'd8, 1'b0, 1'b0);
        @(negedge clk_i);
        digit_valid_i = 1'b0; rst_i = 1'b1;
        #1;
        model_reset();
        check_all("midreset");
        @(negedge clk_i) rst_i = 1'b0;
        step("d5", 1'b1, 4'd5, 1'b0, 1'b0);
        step("ent5", 1'b0, 4'd0, 1'b1, 1'b0);
        chk("req035.bin", 32'(bin_o), 5);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                idle("rnd_idle", TMO + 1);
            end else begin
                dv  = ($urandom_range(0, 99) < 45);
                d   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
                en  = ($urandom_range(0, 3) == 0);
                clr = ($urandom_range(0, 19) == 0);
                step("rnd", dv, d, en, clr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
